// File: rtl/des_region_dispatcher_if.sv
// des_region_dispatcher_if: job, DES and result channels of the region dispatcher
interface des_region_dispatcher_if #(
  parameter int REGION_W = 16,
  parameter int CNT_W = 10
);
  logic job_valid;
  logic job_ready;
  logic [REGION_W-1:0] job_region;
  logic des_start;
  logic [REGION_W-1:0] des_region_select;
  logic des_valid;
  logic [CNT_W-1:0] des_counter;
  logic des_done;
  logic res_valid;
  logic res_ready;
  logic [REGION_W-1:0] res_region;
  logic [CNT_W-1:0] res_counter;
  modport master (
    output job_valid, job_region, des_valid, des_counter, des_done, res_ready,
    input job_ready, des_start, des_region_select, res_valid, res_region, res_counter
  );
  modport slave (
    input job_valid, job_region, des_valid, des_counter, des_done, res_ready,
    output job_ready, des_start, des_region_select, res_valid, res_region, res_counter
  );
endinterface

// File: rtl/des_region_dispatcher.sv
// des_region_dispatcher: launches DES region jobs, supervises completion/timeout, queues hits
module des_region_dispatcher #(
  parameter int REGION_W = 16,
  parameter int CNT_W = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  des_region_dispatcher_if.slave bus,
  output logic busy,
  output logic overflow,
  output logic timeout,
  output logic [15:0] jobs_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;
  state_t state;
  logic [TW-1:0] tcnt;
  logic [REGION_W+CNT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop, wr;
  assign push = state == RUN && bus.des_valid;
  assign pop = bus.res_valid && bus.res_ready;
  // A full FIFO still accepts a hit when the head leaves in the same cycle
  assign wr = push && (count != FULL || pop);
  assign bus.res_valid = count != '0;
  assign {bus.res_region, bus.res_counter} = bus.res_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.job_ready <= 1'b0;
      bus.des_start <= 1'b0;
      bus.des_region_select <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
      jobs_done <= '0;
      tcnt <= '0;
    end else begin
      bus.des_start <= 1'b0;
      case (state)
        IDLE:
          if (bus.job_valid && bus.job_ready) begin
            bus.des_region_select <= bus.job_region;
            bus.des_start <= 1'b1;
            bus.job_ready <= 1'b0;
            busy <= 1'b1;
            state <= LAUNCH;
          end else begin
            bus.job_ready <= 1'b1;
          end
        LAUNCH: begin
          tcnt <= '0;
          state <= RUN;
        end
        RUN:
          // des_done wins over a coincident timeout
          if (bus.des_done || tcnt == T_LAST) begin
            timeout <= timeout | ~bus.des_done;
            jobs_done <= jobs_done + 16'd1;
            busy <= 1'b0;
            bus.job_ready <= 1'b1;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW + 1)'(wr) - (AW + 1)'(pop);
      if (push && !wr) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= {bus.des_region_select, bus.des_counter};
endmodule

// File: tb/tb_des_region_dispatcher.sv
// tb_des_region_dispatcher: directed vectors plus hand sequences for the region dispatcher
module tb_des_region_dispatcher;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, overflow, timeout;
  logic [15:0] jobs_done;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  des_region_dispatcher_if #(.REGION_W(16), .CNT_W(10)) bus();
  des_region_dispatcher #(.REGION_W(16), .CNT_W(10), .FIFO_DEPTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .overflow(overflow),
    .timeout(timeout), .jobs_done(jobs_done)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  typedef struct {
    logic [15:0] region;
    int hit_at;
    logic [9:0] hit_cnt;
    int done_at;
  } vec_t;
  vec_t vecs [5];
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pop(string n, logic [15:0] r, logic [9:0] c);
    chk({n, "_valid"}, 32'(bus.res_valid), 1);
    chk({n, "_region"}, 32'(bus.res_region), 32'(r));
    chk({n, "_cnt"}, 32'(bus.res_counter), 32'(c));
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask
  // Offers a job with stray des_valid pulses during accept/launch, which must be ignored
  task automatic launch(logic [15:0] r);
    for (int i = 0; i < 10 && !bus.job_ready; i++) step();
    chk("job_ready_wait", 32'(bus.job_ready), 1);
    bus.job_valid = 1'b1;
    bus.job_region = r;
    bus.des_valid = 1'b1;
    bus.des_counter = 10'h155;
    step();
    start_cyc = cyc;
    chk("start_pulse", 32'(bus.des_start), 1);
    chk("region_sel", 32'(bus.des_region_select), 32'(r));
    chk("busy_launch", 32'(busy), 1);
    chk("ready_launch", 32'(bus.job_ready), 0);
    bus.job_valid = 1'b0;
    bus.job_region = 16'h0;
    step();
    chk("start_one_cycle", 32'(bus.des_start), 0);
    bus.des_valid = 1'b0;
  endtask
  initial begin
    int k, runlen, exp_jobs, last_start;
    logic to_exp, exp_to;
    vecs[0] = '{16'h0001, 0, 10'd7, 1};
    vecs[1] = '{16'h0002, 0, 10'd7, 0};
    vecs[2] = '{16'h00FF, 15, 10'h3FF, 15};
    vecs[3] = '{16'hBEEF, 2, 10'd0, -1};
    vecs[4] = '{16'h5A5A, 20, 10'd1, 4};
    bus.job_valid = 1'b0;
    bus.job_region = '0;
    bus.des_valid = 1'b0;
    bus.des_counter = '0;
    bus.des_done = 1'b0;
    bus.res_ready = 1'b0;
    step();
    step();
    chk("rst_job_ready", 32'(bus.job_ready), 0);
    chk("rst_des_start", 32'(bus.des_start), 0);
    chk("rst_sel", 32'(bus.des_region_select), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_region", 32'(bus.res_region), 0);
    chk("rst_res_counter", 32'(bus.res_counter), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_status", {29'b0, overflow, timeout, 1'b0}, 0);
    chk("rst_jobs_done", 32'(jobs_done), 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(bus.job_ready), 1);
    // Single job with three hits, the last coincident with des_done
    launch(16'h1234);
    bus.des_valid = 1'b1;
    bus.des_counter = 10'd0;
    step();
    bus.des_counter = 10'd5;
    step();
    chk("busy_run", 32'(busy), 1);
    bus.des_counter = 10'd1023;
    bus.des_done = 1'b1;
    step();
    bus.des_valid = 1'b0;
    bus.des_done = 1'b0;
    chk("t1_busy", 32'(busy), 0);
    chk("t1_jobs", 32'(jobs_done), 1);
    chk("t1_timeout", 32'(timeout), 0);
    pop("t1_r0", 16'h1234, 10'd0);
    pop("t1_r1", 16'h1234, 10'd5);
    pop("t1_r2", 16'h1234, 10'd1023);
    chk("t1_empty", 32'(bus.res_valid), 0);
    // Fill to 8, drop the 9th, then push+pop while full
    launch(16'hABCD);
    for (int i = 0; i < 9; i++) begin
      bus.des_valid = 1'b1;
      bus.des_counter = 10'(16 + i);
      step();
      if (i == 7) chk("ovf_not_yet", 32'(overflow), 0);
    end
    chk("ovf_set", 32'(overflow), 1);
    bus.des_counter = 10'h099;
    bus.res_ready = 1'b1;
    step();
    bus.des_valid = 1'b0;
    bus.res_ready = 1'b0;
    chk("ovf_head_after_pp", 32'(bus.res_counter), 32'h11);
    bus.des_done = 1'b1;
    step();
    bus.des_done = 1'b0;
    chk("ovf_jobs", 32'(jobs_done), 2);
    for (int i = 1; i < 8; i++) pop("ovf_pop", 16'hABCD, 10'(16 + i));
    pop("ovf_last", 16'hABCD, 10'h099);
    chk("ovf_empty", 32'(bus.res_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    // Reset mid-job with results queued
    launch(16'h0777);
    for (int i = 1; i <= 3; i++) begin
      bus.des_valid = 1'b1;
      bus.des_counter = 10'(i);
      step();
    end
    bus.des_valid = 1'b0;
    chk("mid_queued", 32'(bus.res_valid), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_res_valid", 32'(bus.res_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_overflow", 32'(overflow), 0);
    chk("mid_timeout", 32'(timeout), 0);
    chk("mid_jobs", 32'(jobs_done), 0);
    bus.des_valid = 1'b1;
    bus.des_counter = 10'd9;
    step();
    step();
    step();
    bus.des_valid = 1'b0;
    chk("idle_hits_ignored", 32'(bus.res_valid), 0);
    // Table-driven jobs: completion, coincident hit/done, done on last cycle, timeout
    exp_jobs = 0;
    exp_to = 1'b0;
    last_start = 0;
    for (int v = 0; v < 5; v++) begin
      launch(vecs[v].region);
      if (v > 0) chk("start_gap", 32'(start_cyc - last_start >= 3), 1);
      last_start = start_cyc;
      to_exp = !(vecs[v].done_at >= 0 && vecs[v].done_at < 16);
      runlen = to_exp ? 16 : vecs[v].done_at + 1;
      k = 0;
      while (k < 40) begin
        bus.des_valid = (k == vecs[v].hit_at);
        bus.des_counter = vecs[v].hit_cnt;
        bus.des_done = (k == vecs[v].done_at);
        step();
        k++;
        if (!busy) break;
      end
      bus.des_valid = 1'b0;
      bus.des_done = 1'b0;
      exp_jobs++;
      exp_to = exp_to | to_exp;
      chk("vec_run_len", 32'(k), 32'(runlen));
      chk("vec_timeout", 32'(timeout), 32'(exp_to));
      chk("vec_jobs", 32'(jobs_done), 32'(exp_jobs));
      if (vecs[v].hit_at < runlen) pop("vec_hit", vecs[v].region, vecs[v].hit_cnt);
      chk("vec_empty", 32'(bus.res_valid), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
